// File: rtl/canny_pkg.sv
// rtl/canny_pkg.sv - shared widths and types for the Sobel gradient stage
package canny_pkg;

  localparam int PIX_W_DEF  = 8;
  localparam int GRAD_W_DEF = 11;

  typedef logic [PIX_W_DEF-1:0]         pix_t;
  typedef logic signed [GRAD_W_DEF-1:0] grad_t;

  typedef struct packed {
    grad_t gx;
    grad_t gy;
    logic  last;
  } grad_pair_t;

endpackage

// File: rtl/canny_sobel_grad_if.sv
// rtl/canny_sobel_grad_if.sv - pixel-in / gradient-out stream bundle
interface canny_sobel_grad_if import canny_pkg::*; #(
  parameter int PIX_W  = PIX_W_DEF,
  parameter int GRAD_W = GRAD_W_DEF
);

  logic                     in_valid;
  logic                     in_ready;
  logic [PIX_W-1:0]         in_pixel;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [GRAD_W-1:0] out_gx;
  logic signed [GRAD_W-1:0] out_gy;
  logic                     out_last;

  // pixel source / gradient sink side
  modport master (
    output in_valid, in_pixel, out_ready,
    input  in_ready, out_valid, out_gx, out_gy, out_last
  );

  // Sobel stage side
  modport slave (
    input  in_valid, in_pixel, out_ready,
    output in_ready, out_valid, out_gx, out_gy, out_last
  );

endinterface

// File: rtl/canny_line_buf.sv
// rtl/canny_line_buf.sv - one-row line buffer, async read, write on transfer
module canny_line_buf #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 16,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Read is combinational so the old column is visible in the same cycle it is overwritten
  assign o_rdata = r_mem[i_addr];

  // Contents need no reset: output is gated until two fresh rows have been written
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

endmodule

// File: rtl/canny_sobel_grad.sv
// rtl/canny_sobel_grad.sv - streaming 3x3 Sobel gx/gy with one-deep output register
module canny_sobel_grad import canny_pkg::*; #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int PIX_W  = PIX_W_DEF,
  parameter int GRAD_W = GRAD_W_DEF
) (
  input logic               clk,
  input logic               reset,
  canny_sobel_grad_if.slave bus
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  logic [CW-1:0]            r_col;
  logic [RW-1:0]            r_row;
  logic [PIX_W-1:0]         r_win [3][3];
  logic [2*PIX_W-1:0]       w_lb_rd;
  logic                     r_pend;
  logic                     r_pend_last;
  logic                     r_out_valid;
  logic                     r_out_last;
  logic signed [GRAD_W-1:0] r_out_gx;
  logic signed [GRAD_W-1:0] r_out_gy;
  logic signed [GRAD_W-1:0] w_gx;
  logic signed [GRAD_W-1:0] w_gy;
  logic                     w_in_ready;
  logic                     w_xfer;
  logic                     w_complete;
  logic                     w_frame_end;
  logic                     w_load;

  function automatic logic signed [GRAD_W-1:0] ext(input logic [PIX_W-1:0] p);
    return {{(GRAD_W-PIX_W){1'b0}}, p};
  endfunction

  assign w_in_ready  = bus.out_ready || !r_out_valid;
  assign w_xfer      = bus.in_valid && w_in_ready;
  assign w_complete  = (r_row >= RW'(2)) && (r_col >= CW'(2));
  assign w_frame_end = (r_row == ROW_MAX) && (r_col == COL_MAX);
  // r_pend can only be held back while the output is stalled, which also blocks input,
  // so the window is never shifted under an unconsumed result
  assign w_load      = r_pend && w_in_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_gx    = r_out_gx;
  assign bus.out_gy    = r_out_gy;
  assign bus.out_last  = r_out_last;

  // Packed line buffer: upper half is two rows back, lower half is one row back
  canny_line_buf #(
    .DEPTH (IMG_W),
    .WIDTH (2*PIX_W),
    .AW    (CW)
  ) u_line_buf (
    .clk     (clk),
    .i_we    (w_xfer),
    .i_addr  (r_col),
    .i_wdata ({w_lb_rd[PIX_W-1:0], bus.in_pixel}),
    .o_rdata (w_lb_rd)
  );

  // Raster position of the next incoming pixel
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_xfer) begin
      if (r_col == COL_MAX) begin
        r_col <= '0;
        r_row <= (r_row == ROW_MAX) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // 3x3 window shifts left; right column is {two rows up, one row up, incoming}
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          r_win[r][c] <= '0;
    end else if (w_xfer) begin
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= r_win[r][1];
        r_win[r][1] <= r_win[r][2];
      end
      r_win[0][2] <= w_lb_rd[2*PIX_W-1:PIX_W];
      r_win[1][2] <= w_lb_rd[PIX_W-1:0];
      r_win[2][2] <= bus.in_pixel;
    end
  end

  // Marks that the window holds a complete, not yet emitted neighbourhood
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
    end else if (w_xfer) begin
      r_pend      <= w_complete;
      r_pend_last <= w_frame_end;
    end else if (w_load) begin
      r_pend      <= 1'b0;
    end
  end

  // Sobel kernels on zero-extended pixels; full range fits without saturation
  always_comb begin
    w_gx = '0;
    w_gy = '0;
    w_gx = (ext(r_win[0][2]) + ext(r_win[1][2]) + ext(r_win[1][2]) + ext(r_win[2][2]))
         - (ext(r_win[0][0]) + ext(r_win[1][0]) + ext(r_win[1][0]) + ext(r_win[2][0]));
    w_gy = (ext(r_win[2][0]) + ext(r_win[2][1]) + ext(r_win[2][1]) + ext(r_win[2][2]))
         - (ext(r_win[0][0]) + ext(r_win[0][1]) + ext(r_win[0][1]) + ext(r_win[0][2]));
  end

  // Output register: load a pending result, otherwise drop valid once accepted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_gx    <= '0;
      r_out_gy    <= '0;
      r_out_last  <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_gx    <= w_gx;
      r_out_gy    <= w_gy;
      r_out_last  <= r_pend_last;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_canny_sobel_grad.sv
// tb/tb_canny_sobel_grad.sv - directed self-checking bench for canny_sobel_grad
module tb_canny_sobel_grad;
  import canny_pkg::*;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int NP = (W-2)*(H-2);

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  grad_pair_t q[$];
  grad_pair_t ramp_ref[$];

  always #5 clk = ~clk;

  canny_sobel_grad_if #(.PIX_W(8), .GRAD_W(11)) bus ();

  canny_sobel_grad #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .GRAD_W(11)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // capture every accepted pair
  always @(negedge clk) begin
    grad_pair_t e;
    if (reset && bus.out_valid && bus.out_ready) begin
      e.gx = bus.out_gx;
      e.gy = bus.out_gy;
      e.last = bus.out_last;
      q.push_back(e);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] pix(input int kind, input int r, input int c);
    case (kind)
      0: return 8'd128;
      1: return 8'(10*c);
      2: return (c < 4) ? 8'd0 : 8'd255;
      3: return (c < 4) ? 8'd255 : 8'd0;
      4: return (r < 3) ? 8'd0 : 8'd200;
      default: return 8'd50;
    endcase
  endfunction

  task automatic send(input logic [7:0] p, input bit bubbles);
    int n;
    bit ok;
    if (bubbles) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_pixel = p;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout in_ready=0 required=1");
    end
  endtask

  task automatic send_frame(input int kind, input bit bubbles);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send(pix(kind, r, c), bubbles);
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_pixel = '0;
    bus.out_ready = 1'b1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.out_gx !== 11'sd0) begin bad++; $display("FAIL reset_out_gx got=%0d exp=0", bus.out_gx); end
    total++; if (bus.out_gy !== 11'sd0) begin bad++; $display("FAIL reset_out_gy got=%0d exp=0", bus.out_gy); end
    total++; if (bus.out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b exp=0", bus.out_last); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_constant();
    q.delete();
    send_frame(0, 1'b0);
    drain();
    total++; if (q.size() != NP) begin bad++; $display("FAIL const_count got=%0d exp=%0d", q.size(), NP); end
    for (int k = 0; k < q.size() && k < NP; k++) begin
      total++;
      if (q[k].gx !== 11'sd0 || q[k].gy !== 11'sd0 || q[k].last !== (k == NP-1)) begin
        bad++;
        $display("FAIL const_pair%0d got gx=%0d gy=%0d last=%b exp gx=0 gy=0 last=%b", k, q[k].gx, q[k].gy, q[k].last, k == NP-1);
      end
    end
  endtask

  task automatic test_ramp();
    q.delete();
    send_frame(1, 1'b0);
    drain();
    total++; if (q.size() != NP) begin bad++; $display("FAIL ramp_count got=%0d exp=%0d", q.size(), NP); end
    for (int k = 0; k < q.size() && k < NP; k++) begin
      total++;
      if (q[k].gx !== 11'sd80 || q[k].gy !== 11'sd0 || q[k].last !== (k == NP-1)) begin
        bad++;
        $display("FAIL ramp_pair%0d got gx=%0d gy=%0d last=%b exp gx=80 gy=0", k, q[k].gx, q[k].gy, q[k].last);
      end
    end
    ramp_ref = q;
  endtask

  task automatic test_vstep(input bit inverted);
    logic signed [10:0] big;
    logic signed [10:0] egx;
    big = inverted ? 11'sh404 : 11'sh3FC;
    q.delete();
    send_frame(inverted ? 3 : 2, 1'b0);
    drain();
    total++; if (q.size() != NP) begin bad++; $display("FAIL vstep_count got=%0d exp=%0d", q.size(), NP); end
    for (int k = 0; k < q.size() && k < NP; k++) begin
      int c;
      c = 1 + k % (W-2);
      egx = (c == 3 || c == 4) ? big : 11'sd0;
      total++;
      if (q[k].gx !== egx || q[k].gy !== 11'sd0) begin
        bad++;
        $display("FAIL vstep%0d_pair%0d got gx=%0d gy=%0d exp gx=%0d gy=0", inverted, k, q[k].gx, q[k].gy, egx);
      end
    end
  endtask

  task automatic test_hstep();
    logic signed [10:0] egy;
    q.delete();
    send_frame(4, 1'b0);
    drain();
    total++; if (q.size() != NP) begin bad++; $display("FAIL hstep_count got=%0d exp=%0d", q.size(), NP); end
    for (int k = 0; k < q.size() && k < NP; k++) begin
      int r;
      r = 1 + k / (W-2);
      egy = (r == 2 || r == 3) ? 11'sd800 : 11'sd0;
      total++;
      if (q[k].gx !== 11'sd0 || q[k].gy !== egy) begin
        bad++;
        $display("FAIL hstep_pair%0d got gx=%0d gy=%0d exp gx=0 gy=%0d", k, q[k].gx, q[k].gy, egy);
      end
    end
  endtask

  task automatic test_backpressure();
    int seen;
    grad_pair_t held;
    seen = 0;
    held = '0;
    q.delete();
    fork
      send_frame(1, 1'b0);
      begin
        repeat (30) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          if (bus.out_valid) begin
            total++;
            if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b exp=0", bus.in_ready); end
            if (seen == 0) begin
              held.gx = bus.out_gx; held.gy = bus.out_gy; held.last = bus.out_last;
            end else begin
              total++;
              if (bus.out_gx !== held.gx || bus.out_gy !== held.gy || bus.out_last !== held.last) begin
                bad++;
                $display("FAIL stall_hold got gx=%0d gy=%0d exp gx=%0d gy=%0d", bus.out_gx, bus.out_gy, held.gx, held.gy);
              end
            end
            seen++;
          end
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    total++; if (seen != 5) begin bad++; $display("FAIL stall_cycles got=%0d exp=5", seen); end
    total++; if (q.size() != ramp_ref.size()) begin bad++; $display("FAIL stall_count got=%0d exp=%0d", q.size(), ramp_ref.size()); end
    for (int k = 0; k < q.size() && k < ramp_ref.size(); k++) begin
      total++;
      if (q[k] !== ramp_ref[k]) begin bad++; $display("FAIL stall_pair%0d got=%h exp=%h", k, q[k], ramp_ref[k]); end
    end
  endtask

  task automatic test_bubbles();
    q.delete();
    send_frame(1, 1'b1);
    drain();
    total++; if (q.size() != ramp_ref.size()) begin bad++; $display("FAIL bubble_count got=%0d exp=%0d", q.size(), ramp_ref.size()); end
    for (int k = 0; k < q.size() && k < ramp_ref.size(); k++) begin
      total++;
      if (q[k] !== ramp_ref[k]) begin bad++; $display("FAIL bubble_pair%0d got=%h exp=%h", k, q[k], ramp_ref[k]); end
    end
  endtask

  task automatic test_midframe_reset();
    q.delete();
    for (int i = 0; i < 20; i++) send(pix(1, i / W, i % W), 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midreset_out_valid got=%b exp=0", bus.out_valid); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    for (int i = 0; i < 2*W; i++) send(8'd50, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    total++; if (q.size() != 0) begin bad++; $display("FAIL midreset_early got=%0d exp=0", q.size()); end
    for (int i = 2*W; i < W*H; i++) send(8'd50, 1'b0);
    send_frame(5, 1'b0);
    drain();
    total++; if (q.size() != 2*NP) begin bad++; $display("FAIL midreset_count got=%0d exp=%0d", q.size(), 2*NP); end
    for (int k = 0; k < q.size() && k < 2*NP; k++) begin
      total++;
      if (q[k].gx !== 11'sd0 || q[k].gy !== 11'sd0 || q[k].last !== (k == NP-1 || k == 2*NP-1)) begin
        bad++;
        $display("FAIL midreset_pair%0d got gx=%0d gy=%0d last=%b", k, q[k].gx, q[k].gy, q[k].last);
      end
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_ramp();
    test_vstep(1'b0);
    test_vstep(1'b1);
    test_hstep();
    test_backpressure();
    test_bubbles();
    test_midframe_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
